ula_sequenciador: RTL and testbench
===================================

# ula_sequenciador

Multi-byte operation sequencer that sits directly upstream of the 8-bit ALU (`ula_8_bits`). It accepts one BYTES-wide operation through a valid/ready handshake. It feeds the ALU one byte slice per cycle, LSB first, and chains the ALU carry between slices through a register. It assembles the full-width result, final carry and aggregate equality flag, and presents them downstream through a second valid/ready handshake.

## Interface
- BYTES, 4: operand width in bytes; legal range 2..8; data width W = 8*BYTES
- clk  in  1  clock; all state updates on the rising edge
- rst_n  in  1  reset; asynchronous assert, active-low
- in_valid  in  1  upstream offers an operation
- in_ready  out  1  block can accept an operation
- in_a, in_b  in  W  operands
- in_s  in  4  ALU function select
- in_m  in  1  ALU mode
- in_c_in  in  1  carry into byte 0, passed to the ALU unmodified (no polarity interpretation here)
- alu_a, alu_b  out  8  current byte slice driven to the ALU
- alu_s  out  4  latched in_s
- alu_m  out  1  latched in_m
- alu_c_in  out  1  carry for the current slice
- alu_f  in  8  ALU result (combinational from alu_* outputs)
- alu_c_out  in  1  ALU carry out
- alu_a_eq_b  in  1  ALU equality output
- out_valid  out  1  result available
- out_ready  in  1  downstream accepts the result
- out_f  out  W  assembled result
- out_c_out  out  1  carry out of the last byte
- out_a_eq_b  out  1  AND of alu_a_eq_b over all slices

## Operation
- FSM states:
  - IDLE: in_ready=1. On in_valid, latch in_a, in_b, in_s, in_m, in_c_in; set idx=0, carry=in_c_in, eq=1; go to RUN.
  - RUN: in_ready=0. Drive alu_a=a_reg[8*idx+:8], alu_b=b_reg[8*idx+:8], alu_c_in=carry. On each edge:
    - f_reg[8*idx+:8] ← alu_f
    - carry ← alu_c_out
    - eq ← eq & alu_a_eq_b
    - idx ← idx+1
    - when idx==BYTES-1, go to DONE instead of incrementing.
  - DONE: out_valid=1; out_f=f_reg, out_c_out=carry, out_a_eq_b=eq. All outputs held stable until out_ready=1, then go to IDLE.
- in_ready and out_valid are decoded from state only. No combinational path from in_valid to in_ready or from out_ready to out_valid.
- alu_s and alu_m are constant for the whole operation, equal to the latched values.
- Outside RUN, alu_a/alu_b drive slice idx of the held registers and alu_c_in drives carry. The ALU outputs are ignored in IDLE and DONE.
- The carry is chained raw in both m=0 and m=1. In logic mode it is meaningless but still reported.
- The idx counter is ceil(log2(BYTES)) bits wide and never wraps inside an operation.
- in_valid is ignored while RUN or DONE; in_a/in_b changes have no effect after acceptance.
- Reset (any state, including mid-RUN) forces:
  - state=IDLE, idx=0
  - all registers 0 (a_reg, b_reg, f_reg, carry, eq, s, m)
  - outputs: in_ready=1, out_valid=0, out_f=0, out_c_out=0, out_a_eq_b=0, alu_*=0
- A partially processed operation is discarded on reset and never reported.

## Timing
- Acceptance edge E (in_valid & in_ready).
- RUN spans edges E+1..E+BYTES, capturing slices 0..BYTES-1.
- out_valid rises after edge E+BYTES.
- Latency from acceptance to out_valid is BYTES cycles.
- If out_ready=1 while out_valid is high, the handshake completes on that edge and in_ready=1 in the next cycle.
- Throughput: one operation per BYTES+2 cycles at best (one DONE cycle, one IDLE cycle).
- The ALU path (alu_* out → alu_f/alu_c_out in → register) must close within one cycle.

## Test plan
The bench uses a stub ALU with f=a+b+c_in, c_out=carry, a_eq_b=(a==b), and BYTES=4.
- Reset then idle: during and after rst_n=0, check in_ready=1, out_valid=0, out_f=0. An in_valid pulse while rst_n=0 is ignored.
- Carry ripple: in_a=0x00FF_FFFF, in_b=0x0000_0001, in_c_in=0. Check out_f=0x0100_0000, out_c_out=0, out_a_eq_b=0, and out_valid exactly 4 cycles after acceptance. Check alu_c_in is 0,1,1,1 across the four RUN cycles.
- Overflow and equality: in_a=in_b=0xFFFF_FFFF, in_c_in=1. Check out_f=0xFFFF_FFFF, out_c_out=1, out_a_eq_b=1.
- Back-pressure: hold out_ready=0 for 10 cycles. Outputs stay stable with in_ready=0, and a second in_valid is not accepted. After out_ready=1 for one cycle, the next operation is accepted one cycle later.
- Reset mid-RUN: assert rst_n=0 at slice 2. Check immediate return to IDLE with all outputs 0. A fresh operation 0x1234_5678+0x1111_1111 then yields 0x2345_6789.
- Select passthrough: in_s=4'b0110, in_m=1. Check alu_s=0110 and alu_m=1 on every RUN cycle, and that both stay unchanged when in_s changes after acceptance.

Source files
------------

// File: rtl/ula_sequenciador.sv
// ula_sequenciador: feeds a BYTES-wide operation through an 8-bit ALU one byte per cycle, LSB first,
// chaining the carry through a register and presenting the assembled result over valid/ready.
module ula_sequenciador #(
    parameter  int BYTES = 4,
    localparam int W     = 8 * BYTES,
    localparam int IW    = $clog2(BYTES)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_a,
    input  logic [W-1:0] in_b,
    input  logic [3:0]   in_s,
    input  logic         in_m,
    input  logic         in_c_in,
    output logic [7:0]   alu_a,
    output logic [7:0]   alu_b,
    output logic [3:0]   alu_s,
    output logic         alu_m,
    output logic         alu_c_in,
    input  logic [7:0]   alu_f,
    input  logic         alu_c_out,
    input  logic         alu_a_eq_b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_f,
    output logic         out_c_out,
    output logic         out_a_eq_b
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [W-1:0]    a_q, a_d, b_q, b_d, f_q, f_d;
    logic [3:0]      s_q, s_d;
    logic            m_q, m_d, carry_q, carry_d, eq_q, eq_d;

    assign in_ready   = state_q == IDLE;
    assign out_valid  = state_q == DONE;
    assign alu_a      = a_q[{idx_q, 3'b000} +: 8];
    assign alu_b      = b_q[{idx_q, 3'b000} +: 8];
    assign alu_s      = s_q;
    assign alu_m      = m_q;
    assign alu_c_in   = carry_q;
    assign out_f      = f_q;
    assign out_c_out  = carry_q;
    assign out_a_eq_b = eq_q;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        a_d     = a_q;
        b_d     = b_q;
        f_d     = f_q;
        s_d     = s_q;
        m_d     = m_q;
        carry_d = carry_q;
        eq_d    = eq_q;
        if (state_q == IDLE && in_valid) begin
            state_d = RUN;
            idx_d   = '0;
            a_d     = in_a;
            b_d     = in_b;
            f_d     = '0;
            s_d     = in_s;
            m_d     = in_m;
            carry_d = in_c_in;
            eq_d    = 1'b1;
        end else if (state_q == RUN) begin
            f_d[{idx_q, 3'b000} +: 8] = alu_f;
            carry_d = alu_c_out;
            eq_d    = eq_q & alu_a_eq_b;
            // idx stays on the last slice so it never wraps inside an operation
            if (idx_q == IW'(BYTES - 1)) state_d = DONE;
            else idx_d = idx_q + 1'b1;
        end else if (state_q == DONE && out_ready) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            f_q     <= '0;
            s_q     <= '0;
            m_q     <= 1'b0;
            carry_q <= 1'b0;
            eq_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            a_q     <= a_d;
            b_q     <= b_d;
            f_q     <= f_d;
            s_q     <= s_d;
            m_q     <= m_d;
            carry_q <= carry_d;
            eq_q    <= eq_d;
        end
    end
endmodule

// File: tb/tb_ula_sequenciador.sv
// tb_ula_sequenciador: directed scoreboard bench with an adder stub standing in for the ALU.
module tb_ula_sequenciador;
    localparam int BYTES = 4;
    localparam int W     = 8 * BYTES;

    logic         clk = 1'b0, rst_n = 1'b0;
    logic         in_valid = 1'b0, in_m = 1'b0, in_c_in = 1'b0, out_ready = 1'b0;
    logic [W-1:0] in_a = '0, in_b = '0;
    logic [3:0]   in_s = '0;
    logic         in_ready, alu_m, alu_c_in, alu_c_out, alu_a_eq_b, out_valid, out_c_out, out_a_eq_b;
    logic [7:0]   alu_a, alu_b, alu_f;
    logic [3:0]   alu_s;
    logic [W-1:0] out_f;

    typedef struct packed {
        logic [W-1:0] f;
        logic         c;
        logic         eq;
    } res_t;

    res_t exp_q[$];
    int   n_cmp = 0, n_err = 0;

    always #5 clk = ~clk;

    assign {alu_c_out, alu_f} = alu_a + alu_b + alu_c_in;
    assign alu_a_eq_b = alu_a == alu_b;

    ula_sequenciador #(.BYTES(BYTES)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_a(in_a), .in_b(in_b), .in_s(in_s), .in_m(in_m), .in_c_in(in_c_in),
        .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_c_in(alu_c_in),
        .alu_f(alu_f), .alu_c_out(alu_c_out), .alu_a_eq_b(alu_a_eq_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_f(out_f), .out_c_out(out_c_out), .out_a_eq_b(out_a_eq_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
        n_cmp++;
        assert (obs === want) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic accept(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic c, input bit push);
        logic [W:0] sum;
        int n = 0;
        while (!in_ready && n < 20) begin
            step();
            n++;
        end
        chk("accept_ready", in_ready, 1);
        in_a = a; in_b = b; in_s = s; in_m = m; in_c_in = c; in_valid = 1'b1;
        sum = a + b + c;
        if (push) exp_q.push_back(res_t'{f: sum[W-1:0], c: sum[W], eq: a == b});
        step();
        in_valid = 1'b0;
    endtask

    task automatic get_result();
        res_t r;
        int n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
        chk("out_valid_wait", out_valid, 1);
        chk("sb_nonempty", exp_q.size() != 0, 1);
        if (exp_q.size() != 0) begin
            r = exp_q.pop_front();
            chk("out_f", out_f, r.f);
            chk("out_c_out", out_c_out, r.c);
            chk("out_a_eq_b", out_a_eq_b, r.eq);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("post_hs_in_ready", in_ready, 1);
        chk("post_hs_out_valid", out_valid, 0);
    endtask

    // Checks every RUN cycle against an arithmetic carry model, then the latency and result.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic [3:0] s,
                          input logic m, input logic c);
        logic [63:0] mk, t;
        accept(a, b, s, m, c, 1'b1);
        for (int i = 0; i < BYTES; i++) begin
            mk = (64'd1 << (8 * i)) - 64'd1;
            t  = ({32'b0, a} & mk) + ({32'b0, b} & mk) + {63'b0, c};
            chk("run_alu_c_in", alu_c_in, t[8*i]);
            chk("run_alu_a", alu_a, a[8*i +: 8]);
            chk("run_alu_b", alu_b, b[8*i +: 8]);
            chk("run_alu_s", alu_s, s);
            chk("run_alu_m", alu_m, m);
            chk("run_out_valid", out_valid, 0);
            chk("run_in_ready", in_ready, 0);
            in_s = ~s;
            in_m = ~m;
            in_a = ~a;
            step();
        end
        chk("latency_out_valid", out_valid, 1);
        get_result();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        // reset with an in_valid pulse that must be ignored
        in_valid = 1'b1; in_a = 32'hDEAD_BEEF; in_b = 32'h0BAD_F00D;
        step();
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_f", out_f, 0);
        step();
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();
        chk("idle_in_ready", in_ready, 1);
        chk("idle_out_valid", out_valid, 0);
        chk("idle_out_f", out_f, 0);
        chk("idle_alu_a", alu_a, 0);

        // carry ripple: alu_c_in should run 0,1,1,1
        run_op(32'h00FF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0);
        // overflow with equal operands
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'b1001, 1'b0, 1'b1);

        // back-pressure: a second offer sits on in_valid throughout DONE
        accept(32'h1234_5678, 32'h1111_1111, 4'b1001, 1'b0, 1'b0, 1'b0);
        repeat (BYTES) step();
        in_a = 32'h0101_0101; in_b = 32'h0202_0202; in_c_in = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            chk("bp_out_valid", out_valid, 1);
            chk("bp_in_ready", in_ready, 0);
            chk("bp_out_f", out_f, 32'h2345_6789);
            chk("bp_out_c_out", out_c_out, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk("bp_hs_in_ready", in_ready, 1);
        chk("bp_hs_out_valid", out_valid, 0);
        exp_q.push_back(res_t'{f: 32'h0303_0303, c: 1'b0, eq: 1'b0});
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", in_ready, 0);
        get_result();

        // reset in the middle of RUN discards the operation
        accept(32'hDEAD_BEEF, 32'h0102_0304, 4'b0011, 1'b1, 1'b1, 1'b0);
        step();
        step();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", in_ready, 1);
        chk("mid_rst_out_valid", out_valid, 0);
        chk("mid_rst_out_f", out_f, 0);
        chk("mid_rst_out_c_out", out_c_out, 0);
        chk("mid_rst_out_a_eq_b", out_a_eq_b, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_alu_c_in", alu_c_in, 0);
        chk("mid_rst_alu_s", alu_s, 0);
        chk("mid_rst_alu_m", alu_m, 0);
        step();
        rst_n = 1'b1;
        step();
        chk("mid_rst_no_output", out_valid, 0);
        run_op(32'h1234_5678, 32'h1111_1111, 4'b0000, 1'b0, 1'b0);

        // select passthrough, held while in_s/in_m change after acceptance
        run_op(32'hA5A5_0F0F, 32'h5A5A_F0F0, 4'b0110, 1'b1, 1'b0);

        chk("sb_drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
